// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and parity helper
//
// Purpose: state encoding, data/frame widths and the parity function used by
// the UART transmit path.
// Ports: none (package).

package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

  // Even parity is the plain XOR of the data bits; odd parity inverts it.
  function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data,
                                       input logic                   odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_frame_sm_if.sv
// rtl/uart_tx_frame_sm_if.sv - byte handshake bundle into the UART transmitter
//
// Purpose: groups the valid/ready byte handshake feeding uart_tx_frame_sm.
// Signals: tx_data (byte), tx_valid (byte offered), tx_ready (byte accepted
// on a posedge with tx_valid && tx_ready).
// Modports: master drives data/valid, slave (the transmitter) drives ready.

interface uart_tx_frame_sm_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - input byte buffer for the UART transmitter
//
// Purpose: buffers accepted bytes until the framing FSM pops them.
// Build option: UART_TX_FIFO_EN defined selects a FIFO_DEPTH-entry circular
// FIFO; otherwise a single holding register with a valid flag is used and
// FIFO_DEPTH has no effect.
// Ports: clk, reset (async active-low), push/wdata (write), pop (read),
// head (oldest byte), full, empty.

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] head,
  output logic                   full,
  output logic                   empty
);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [UART_DATA_W-1:0] r_mem [FIFO_DEPTH];
  // One extra pointer bit tells a full buffer apart from an empty one.
  logic [AW:0]            r_wptr;
  logic [AW:0]            r_rptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  assign head  = r_mem[r_rptr[AW-1:0]];
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
`else
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_valid;

  // push only happens while empty and pop only while full, so they never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (push) begin
      r_data  <= wdata;
      r_valid <= 1'b1;
    end else if (pop) begin
      r_valid <= 1'b0;
    end
  end

  assign head  = r_data;
  assign full  = r_valid;
  assign empty = !r_valid;
`endif

endmodule

// File: rtl/uart_tx_frame_sm.sv
// rtl/uart_tx_frame_sm.sv - UART transmit framing state machine
//
// Purpose: serialises buffered bytes as 11-bit frames (start, d0..d7 LSB
// first, parity, stop) at one bit per clk. mreset from the receiver aborts a
// frame in START/DATA/PARITY; buffered bytes survive the abort.
// Build option: UART_TX_FIFO_EN (see uart_tx_fifo) selects the buffer type.
// Ports: clk, reset (async active-low), s_tx (byte handshake, slave side),
// mreset (abort request), Tx_out (serial line, idles high), busy (frame in
// flight), frame_done (pulse with the stop bit), abort (pulse on abort).

module uart_tx_frame_sm
  import uart_pkg::*;
#(
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_frame_sm_if.slave  s_tx,
  input  logic               mreset,
  output logic               Tx_out,
  output logic               busy,
  output logic               frame_done,
  output logic               abort
);

  localparam logic [2:0] S_IDLE   = UART_IDLE;
  localparam logic [2:0] S_START  = UART_START;
  localparam logic [2:0] S_DATA   = UART_DATA;
  localparam logic [2:0] S_PARITY = UART_PARITY;
  localparam logic [2:0] S_STOP   = UART_STOP;

  logic [2:0]             r_state;
  logic [UART_DATA_W-1:0] r_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_par;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_abort;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_in_frame;
  logic [UART_DATA_W-1:0] w_head;

  assign w_push     = s_tx.tx_valid && !w_full;
  // A new byte is taken from IDLE, or straight from STOP for back-to-back frames.
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP));
  assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_PARITY);

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata (s_tx.tx_data),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Derived from buffer flops only, so no combinational path from the pop.
  assign s_tx.tx_ready = !w_full;

  // Outputs are loaded together with the state, so Tx_out always shows the
  // bit of the state currently held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      if (w_in_frame && mreset) begin
        r_state <= S_IDLE;
        r_tx    <= 1'b1;
        r_busy  <= 1'b0;
        r_abort <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE, S_STOP: begin
            if (!w_empty) begin
              r_state <= S_START;
              r_shift <= w_head;
              r_par   <= uart_parity(w_head, PARITY_ODD != 0);
              r_tx    <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          S_START: begin
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[UART_DATA_W-1:1]};
            r_bit_cnt <= 3'd0;
          end
          S_DATA: begin
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
              r_tx    <= r_par;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[UART_DATA_W-1:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          S_PARITY: begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
            r_done  <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Tx_out     = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign abort      = r_abort;

endmodule

// File: tb/tb_uart_tx_frame_sm.sv
// tb/tb_uart_tx_frame_sm.sv - bench for uart_tx_frame_sm (even and odd parity instances)

module tb_uart_tx_frame_sm;
  import uart_pkg::*;

  localparam int DEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mreset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx0, busy0, done0, abort0;
  logic       tx1, busy1, done1, abort1;

  uart_tx_frame_sm_if if0 ();
  uart_tx_frame_sm_if if1 ();
  assign if0.tx_valid = tx_valid;
  assign if0.tx_data  = tx_data;
  assign if1.tx_valid = tx_valid;
  assign if1.tx_data  = tx_data;

  always #5 clk = ~clk;

  uart_tx_frame_sm #(.PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .s_tx(if0), .mreset(mreset),
    .Tx_out(tx0), .busy(busy0), .frame_done(done0), .abort(abort0));

  uart_tx_frame_sm #(.PARITY_ODD(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .s_tx(if1), .mreset(mreset),
    .Tx_out(tx1), .busy(busy1), .frame_done(done1), .abort(abort1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered bytes and the 11-bit frame being sent,
  // with m_pos the index of the bit on the line (-1 when the line is idle).
  logic [7:0]  stim_q[$];
  logic [7:0]  m_q[$];
  int          m_pos = -1;
  logic [10:0] m_f0 = '1;
  logic [10:0] m_f1 = '1;
  logic        m_abort = 1'b0;
  bit          m_acc = 1'b0;

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic odd);
    return {1'b1, (^d) ^ odd, d, 1'b0};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pos   = -1;
    m_abort = 1'b0;
  endtask

  task automatic model_step();
    bit         ready_pre;
    logic [7:0] d;
    m_acc   = 1'b0;
    m_abort = 1'b0;
    if (!reset) begin
      model_reset();
      return;
    end
    ready_pre = (m_q.size() < CAP);
    if (m_pos >= 0 && m_pos <= 9) begin
      if (mreset) begin
        m_pos   = -1;
        m_abort = 1'b1;
      end else begin
        m_pos++;
      end
    end else if (m_q.size() != 0) begin
      d     = m_q.pop_front();
      m_f0  = mk_frame(d, 1'b0);
      m_f1  = mk_frame(d, 1'b1);
      m_pos = 0;
    end else begin
      m_pos = -1;
    end
    if (tx_valid && ready_pre) begin
      m_q.push_back(tx_data);
      m_acc = 1'b1;
    end
  endtask

  // One clock: offer the head of stim_q, advance the model at the edge,
  // compare every output at the following negedge.
  task automatic cycle();
    logic e0, e1;
    tx_valid = (stim_q.size() != 0);
    tx_data  = (stim_q.size() != 0) ? stim_q[0] : 8'($urandom);
    @(posedge clk);
    model_step();
    if (m_acc) void'(stim_q.pop_front());
    @(negedge clk);
    e0 = (m_pos < 0) ? 1'b1 : m_f0[m_pos];
    e1 = (m_pos < 0) ? 1'b1 : m_f1[m_pos];
    check("tx_out_even", tx0, e0);
    check("tx_out_odd", tx1, e1);
    check("busy", busy0, m_pos >= 0);
    check("busy_odd", busy1, m_pos >= 0);
    check("frame_done", done0, m_pos == 10);
    check("frame_done_odd", done1, m_pos == 10);
    check("abort", abort0, m_abort);
    check("abort_odd", abort1, m_abort);
    check("tx_ready", if0.tx_ready, m_q.size() < CAP);
    check("tx_ready_odd", if1.tx_ready, m_q.size() < CAP);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (m_pos >= 0 || m_q.size() != 0 || stim_q.size() != 0); i++) cycle();
    check("drain_idle", m_pos, -1);
  endtask

  // Sends one byte from idle and records the 11 line bits following the pop.
  task automatic send_capture(input logic [7:0] b, output logic [10:0] f0,
                              output logic [10:0] f1, output logic [10:0] dn);
    stim_q.push_back(b);
    cycle();
    for (int i = 0; i < 11; i++) begin
      cycle();
      f0[i] = tx0;
      f1[i] = tx1;
      dn[i] = done0;
    end
    cycle();
  endtask

  initial begin
    logic [10:0] f0, f1, dn;
    int run, best, ready_low, zeros;

    repeat (3) @(negedge clk);
    check("rst_tx_out", tx0, 1);
    check("rst_busy", busy0, 0);
    check("rst_frame_done", done0, 0);
    check("rst_abort", abort0, 0);
    check("rst_tx_ready", if0.tx_ready, 1);
    reset = 1'b1;
    repeat (2) cycle();

    send_capture(8'hA5, f0, f1, dn);
    check("a5_frame_even", f0, 11'b1_0_1010_0101_0);
    check("a5_frame_odd", f1, 11'b1_1_1010_0101_0);
    check("a5_done_on_stop", dn, 11'b100_0000_0000);

    send_capture(8'h07, f0, f1, dn);
    check("p07_odd", f1[9], 0);
    check("p07_even", f0[9], 1);
    send_capture(8'h03, f0, f1, dn);
    check("p03_odd", f1[9], 1);
    check("p03_even", f0[9], 0);

    stim_q = '{8'h11, 8'h22, 8'h33};
    cycle();
    check("ready_after_first_push", if0.tx_ready, CAP > 1);
    run = 0; best = 0; ready_low = 0;
    for (int i = 0; i < 80 && (best == 0 || m_pos >= 0 || stim_q.size() != 0); i++) begin
      cycle();
      run = busy0 ? run + 1 : 0;
      if (run > best) best = run;
      if (!if0.tx_ready) ready_low++;
    end
    check("b2b_busy_run", best, 33);
`ifdef UART_TX_FIFO_EN
    check("b2b_ready_held", ready_low, 0);
`else
    check("b2b_ready_dropped", ready_low != 0, 1);
`endif
    drain();

    stim_q = '{8'hFF, 8'h5A};
    for (int i = 0; i < 30 && m_pos != 4; i++) cycle();
    check("reach_d3", m_pos, 4);
    mreset = 1'b1;
    cycle();
    mreset = 1'b0;
    check("mreset_line_high", tx0, 1);
    check("mreset_abort", abort0, 1);
    check("mreset_not_busy", busy0, 0);
    cycle();
    check("after_abort_start", tx0, 0);
    check("after_abort_pulse_gone", abort0, 0);
    check("after_abort_busy", busy0, 1);
    drain();

    stim_q = '{8'hC3, 8'h3C};
    for (int i = 0; i < 30 && m_pos != 9; i++) cycle();
    check("reach_parity", m_pos, 9);
    check("parity_even_c3", tx0, 0);
    reset = 1'b0;
    #1;
    check("async_rst_tx_out", tx0, 1);
    check("async_rst_busy", busy0, 0);
    check("async_rst_ready", if0.tx_ready, 1);
    stim_q.delete();
    model_reset();
    repeat (2) cycle();
    reset = 1'b1;
    zeros = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!tx0 || busy0) zeros++;
    end
    check("idle_after_reset", zeros, 0);

    for (int i = 0; i < 1500; i++) begin
      if (stim_q.size() < 2 && $urandom_range(0, 2) == 0) stim_q.push_back(8'($urandom));
      mreset = ($urandom_range(0, 29) == 0);
      cycle();
      mreset = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
